// File: rtl/control_seq.sv
// control_seq: handshaked instruction decoder driving per-register commands and ALU op, with multi-cycle divk
module control_seq #(
   parameter int NREG    = 3,
   parameter int SHAMT_W = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic [2:0]         instrucao,
   input  logic [SHAMT_W-1:0] shamt,
   output logic [2*NREG-1:0]  T,
   output logic [1:0]         Tula,
   output logic               busy,
   output logic               done
);
   localparam logic [1:0] LD = 2'b01, SHR = 2'b10, RST = 2'b11;
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t state, state_n;
   logic [SHAMT_W-1:0] cnt, cnt_n;
   logic [2*NREG-1:0] t_n;
   logic [1:0] tula_n;
   logic done_n, accept, multi;
   assign instr_ready = (state == IDLE);
   assign busy = (state == SHIFT);
   assign accept = instr_valid & instr_ready;
   assign multi = shamt > SHAMT_W'(1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         T     <= '0;
         Tula  <= 2'b00;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         T     <= t_n;
         Tula  <= tula_n;
         done  <= done_n;
      end
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      t_n     = '0;
      tula_n  = 2'b00;
      done_n  = 1'b0;
      if (state == SHIFT) begin
         t_n[3:2] = SHR;
         cnt_n    = cnt - SHAMT_W'(1);
         if (cnt == SHAMT_W'(1)) begin
            state_n = IDLE;
            done_n  = 1'b1;
         end
      end else if (accept) begin
         done_n = 1'b1;
         case (instrucao)
            3'b000: begin t_n[1:0] = LD; t_n[3:2] = RST; t_n[5:4] = RST; end
            3'b001: begin t_n[1:0] = LD; t_n[3:2] = LD; tula_n = 2'b01; end
            3'b010: begin t_n[3:2] = LD; tula_n = 2'b01; end
            3'b011: begin
               t_n[3:2] = (shamt != '0) ? SHR : 2'b00;
               done_n   = !multi;
               if (multi) begin
                  state_n = SHIFT;
                  cnt_n   = shamt - SHAMT_W'(1);
               end
            end
            3'b100: begin t_n[1:0] = RST; t_n[3:2] = RST; t_n[5:4] = LD; end
            3'b101: begin t_n[3:2] = LD; tula_n = 2'b10; end
            3'b110: ;
            default: t_n = '1;
         endcase
      end
   end
endmodule

// File: tb/tb_control_seq.sv
// tb_control_seq: directed checks of control_seq with NREG=5 against hand-computed command words
module tb_control_seq;
   logic clk = 1'b0, rst_n = 1'b0, instr_valid = 1'b0;
   logic [2:0] instrucao = 3'b000, shamt = 3'd0;
   logic instr_ready, busy, done;
   logic [9:0] T;
   logic [1:0] Tula;
   int n_chk = 0, n_fail = 0;

   control_seq #(.NREG(5), .SHAMT_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instrucao(instrucao), .shamt(shamt), .T(T), .Tula(Tula), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      tick; tick;
      rst_n = 1'b1;
      tick;
      chk("rst_T", 32'(T), 32'h0); chk("rst_Tula", 32'(Tula), 0);
      chk("rst_done", 32'(done), 0); chk("rst_busy", 32'(busy), 0); chk("rst_ready", 32'(instr_ready), 1);
      // clrld, addld, add, nop back-to-back
      instr_valid = 1'b1; instrucao = 3'b000;
      tick;
      chk("clrld_T", 32'(T), 32'h03D); chk("clrld_Tula", 32'(Tula), 0); chk("clrld_done", 32'(done), 1);
      instrucao = 3'b001;
      tick;
      chk("addld_T", 32'(T), 32'h005); chk("addld_Tula", 32'(Tula), 1); chk("addld_done", 32'(done), 1);
      instrucao = 3'b010;
      tick;
      chk("add_T", 32'(T), 32'h004); chk("add_Tula", 32'(Tula), 1);
      instrucao = 3'b110;
      tick;
      chk("nop_T", 32'(T), 32'h0); chk("nop_done", 32'(done), 1);
      instr_valid = 1'b0;
      tick;
      chk("idle_T", 32'(T), 32'h0); chk("idle_done", 32'(done), 0);
      // divk 5
      instr_valid = 1'b1; instrucao = 3'b011; shamt = 3'd5;
      tick;
      instr_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("div5_T%0d", i), 32'(T), 32'h008);
         chk($sformatf("div5_busy%0d", i), 32'(busy), (i < 4) ? 1 : 0);
         chk($sformatf("div5_done%0d", i), 32'(done), (i == 4) ? 1 : 0);
         chk($sformatf("div5_ready%0d", i), 32'(instr_ready), (i == 4) ? 1 : 0);
         tick;
      end
      chk("div5_after_T", 32'(T), 32'h0); chk("div5_after_done", 32'(done), 0);
      // divk 3 then sub accepted in last shift cycle
      instr_valid = 1'b1; instrucao = 3'b011; shamt = 3'd3;
      tick;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("div3_T%0d", i), 32'(T), 32'h008);
         chk($sformatf("div3_done%0d", i), 32'(done), (i == 2) ? 1 : 0);
         chk($sformatf("div3_ready%0d", i), 32'(instr_ready), (i == 2) ? 1 : 0);
         if (i == 2) instrucao = 3'b101;
         tick;
      end
      chk("sub_T", 32'(T), 32'h004); chk("sub_Tula", 32'(Tula), 2); chk("sub_done", 32'(done), 1);
      instr_valid = 1'b0;
      tick;
      chk("sub_after_T", 32'(T), 32'h0);
      // divk shamt 0 then 1
      instr_valid = 1'b1; instrucao = 3'b011; shamt = 3'd0;
      tick;
      chk("div0_T", 32'(T), 32'h0); chk("div0_done", 32'(done), 1); chk("div0_busy", 32'(busy), 0);
      shamt = 3'd1;
      tick;
      instr_valid = 1'b0;
      chk("div1_T", 32'(T), 32'h008); chk("div1_done", 32'(done), 1); chk("div1_busy", 32'(busy), 0);
      tick;
      chk("div1_after_T", 32'(T), 32'h0); chk("div1_after_busy", 32'(busy), 0);
      // divk 7 aborted by async reset in its second cycle
      instr_valid = 1'b1; instrucao = 3'b011; shamt = 3'd7;
      tick;
      instr_valid = 1'b0;
      chk("div7_T0", 32'(T), 32'h008); chk("div7_busy0", 32'(busy), 1);
      tick;
      chk("div7_T1", 32'(T), 32'h008);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_T", 32'(T), 32'h0); chk("arst_busy", 32'(busy), 0);
      chk("arst_done", 32'(done), 0); chk("arst_ready", 32'(instr_ready), 1);
      tick; tick;
      rst_n = 1'b1;
      tick;
      chk("post_rst_T", 32'(T), 32'h0); chk("post_rst_busy", 32'(busy), 0);
      instr_valid = 1'b1; instrucao = 3'b100;
      tick;
      chk("disp_T", 32'(T), 32'h01F); chk("disp_done", 32'(done), 1);
      instrucao = 3'b111;
      tick;
      chk("clrall_T", 32'(T), 32'h3FF); chk("clrall_Tula", 32'(Tula), 0); chk("clrall_done", 32'(done), 1);
      instr_valid = 1'b0;
      tick;
      chk("final_T", 32'(T), 32'h0); chk("final_done", 32'(done), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/control_seq.md
Name: control_seq

Overview:
- Parametrised successor to the three-register calculator control unit.
- Accepts instructions through a valid/ready handshake and decodes them into 2-bit register commands (hold/load/shiftr/reset) for NREG registers, plus an ALU op code.
- Adds multi-cycle divide-by-2^k (repeated shiftr), subtract, nop and clear-all.
- Sits between the instruction source (switches/sequencer) and the X/Y/Z register-file datapath.

Parameters:
NREG, 3, number of controlled registers (min 3); index 0 = X, 1 = Y, 2 = Z, indices ≥3 are auxiliary registers
SHAMT_W, 3, width of the shift-count field for divk (max count 2^SHAMT_W-1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
instr_valid  input  1  instruction present on instrucao/shamt
instr_ready  output  1  block can accept an instruction this cycle
instrucao  input  3  opcode
shamt  input  SHAMT_W  shift count, used by divk only
T  output  2*NREG  register commands; field i = T[2i+1:2i]; 00 hold, 01 load, 10 shiftr, 11 reset
Tula  output  2  ALU op; 00 none, 01 add, 10 sub, 11 reserved (never driven)
busy  output  1  high while a multi-cycle divk is in progress (state SHIFT)
done  output  1  one-cycle pulse during the final command cycle of each accepted instruction

Behaviour:
- Reset (async, rst_n=0): state IDLE, cnt=0, all T fields hold (00), Tula=00, done=0, busy=0. instr_ready=1 once rst_n=1. Reset mid-SHIFT aborts the shift immediately; no further shiftr is issued.
- States: IDLE, SHIFT. instr_ready = (state==IDLE), combinational. busy = (state==SHIFT).
- Accept = instr_valid & instr_ready at a rising edge. The source holds instrucao/shamt stable while instr_valid=1 and instr_ready=0. Inputs present while not ready are ignored.
- All outputs are registered. Commands for an accepted instruction appear in the cycle following the accepting edge (latency 1).
- IDLE without accept: all fields hold, Tula=00, done=0.
- Opcode decode. Fields not listed are hold; Tula=00 unless stated. All of these are single-cycle with done=1, except divk:
  - 000 clrld: X load, Y reset, Z reset.
  - 001 addld: X load, Y load, Tula=01.
  - 010 add: Y load, Tula=01.
  - 011 divk: Y shiftr for exactly shamt consecutive cycles.
  - 100 disp: X reset, Y reset, Z load.
  - 101 sub: Y load, Tula=10.
  - 110 nop: all hold.
  - 111 clrall: every field (all NREG) reset.
- divk detail:
  - shamt=0: all hold, done=1, no state change.
  - shamt=1: one shiftr cycle with done=1, stay IDLE.
  - shamt=k>1: at accept, Y=shiftr, cnt<=k-1, state<=SHIFT. At each SHIFT edge, Y stays shiftr and cnt<=cnt-1. When cnt==1 at the edge, state<=IDLE and done<=1.
  - The k-th shiftr cycle therefore has state IDLE, instr_ready=1 and done=1, so back-to-back acceptance adds no bubble.
- Next instruction: accepting in the last divk cycle puts the new command in the following cycle. With no accept, outputs return to hold.
- Auxiliary fields (i≥3) are hold for every opcode except clrall.

Test Plan:
- Reset: rst_n low mid-simulation, async (no clock) -> T=0, Tula=0, done=0, instr_ready=1.
- clrld then addld back-to-back (valid held 2 cycles) -> cycle+1: T[5:0]=111101, Tula=00, done=1; cycle+2: T[5:0]=000101, Tula=01, done=1.
- divk shamt=5 -> 5 consecutive cycles of Y field=10, busy=1 for the first 4 of them, done=1 only on the 5th; then T=0.
- divk shamt=3 followed immediately by sub (valid held) -> sub accepted in the 3rd shift cycle; next cycle Y=01, Tula=10; total shiftr cycles exactly 3.
- divk shamt=0 and shamt=1 -> shamt=0: T=0 with done=1; shamt=1: single Y=10 with done=1, busy never set.
- Reset asserted in the 2nd cycle of divk shamt=7 -> outputs hold immediately. After release, state IDLE, a new disp gives T[5:0]=011111, and with NREG=5, clrall gives T=10'h3FF.
